valu_wb_queue: RTL and testbench
================================

// Module: valu_wb_queue
// PURPOSE
//   Writeback stage directly downstream of the vALU move/arith result pipelines.
//   Their results arrive with no backpressure. Vector results are buffered in a
//   show-ahead FIFO and drained to the VRF write port with a valid/ready handshake.
//   Scalar results are captured in a one-entry holding register until the scalar
//   unit acknowledges them.
//   The block also provides an almost-full flag so issue logic can throttle before
//   results already in flight are lost.
// PARAMETERS
//   DATA_WIDTH   64             result data width (bits)
//   ADDR_WIDTH   32             VRF address width
//   BE_WIDTH     DATA_WIDTH/8   byte-enable width
//   DEPTH        8              FIFO entries; power of 2, >= 2
//   AFULL_THRESH 2              almost_full asserts when free entries <= AFULL_THRESH
// PORTS
//   clk          in   1              clock
//   rst          in   1              synchronous reset, active-high
//   in_valid     in   1              result beat valid (no backpressure)
//   in_vec       in   DATA_WIDTH     result data
//   in_addr      in   ADDR_WIDTH     destination VRF address
//   in_be        in   BE_WIDTH       byte enables
//   in_w_reg     in   1              result targets the widened register group
//   in_sca       in   1              result is a scalar (routes to sca_* port)
//   wb_valid     out  1              head FIFO entry present
//   wb_ready     in   1              VRF accepts a write this cycle
//   wb_data      out  DATA_WIDTH     head entry data
//   wb_addr      out  ADDR_WIDTH     head entry address
//   wb_be        out  BE_WIDTH       head entry byte enables
//   wb_w_reg     out  1              head entry widen flag
//   sca_valid    out  1              scalar result held
//   sca_data     out  DATA_WIDTH     held scalar value
//   sca_ack      in   1              scalar consumer takes the held value
//   count        out  $clog2(DEPTH)+1  FIFO occupancy
//   almost_full  out  1              (DEPTH-count) <= AFULL_THRESH
//   overflow     out  1              sticky: a result beat was dropped
// BEHAVIOUR
//   - Reset: pointers=0, count=0, wb_valid=0, sca_valid=0, sca_data=0, overflow=0.
//     wb_* data outputs are don't-care while wb_valid=0.
//     Reset mid-drain discards all entries and any held scalar.
//   - Vector push: in_valid & ~in_sca.
//     Writes {in_vec, in_addr, in_be, in_w_reg} at the write pointer.
//     Entries with in_be==0 are still queued.
//   - Pop: wb_valid & wb_ready advances the read pointer.
//     wb_valid = (count!=0). wb_* are driven from the head entry (show-ahead).
//     wb_ready while empty is ignored.
//   - Latency: a push into an empty FIFO shows wb_valid=1 on the next cycle.
//     There is no same-cycle bypass.
//   - Full: a push with count==DEPTH and no pop in the same cycle is dropped.
//     The drop sets overflow. Contents and count are unchanged.
//     A push with count==DEPTH and a pop in the same cycle is accepted; count stays DEPTH.
//   - Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged.
//   - Pointers wrap modulo DEPTH; count tracks occupancy with the extra MSB.
//   - Scalar path: in_valid & in_sca loads sca_data<=in_vec and sets sca_valid=1 next cycle.
//     sca_ack & sca_valid clears sca_valid, unless a scalar loads in the same cycle.
//     In that case the new value replaces the old one and sca_valid stays 1.
//     A scalar arriving while sca_valid=1 and ~sca_ack is dropped and sets overflow.
//     The held value is kept.
//   - Scalar beats never enter the FIFO. in_w_reg is ignored for scalars.
//   - in_* are sampled only when in_valid=1.
//   - overflow clears only on rst.
// TESTING
//   - Reset, wb_ready=1, push 3 beats (addr 0x10,0x11,0x12) -> wb_valid from the
//     following cycle; 3 writes delivered in order with matching data/be;
//     count back to 0.
//   - wb_ready=0, DEPTH=8, push 8 beats -> count=8, almost_full=1 from count=6;
//     a 9th push -> dropped, overflow=1; then wb_ready=1 -> exactly the first 8 drain.
//   - FIFO full, push and pop in the same cycle -> count stays 8; the new beat is
//     delivered after the 7 older ones.
//   - Scalar 0xDEAD with in_sca=1 -> sca_valid=1 next cycle, FIFO count=0.
//     Second scalar 0xBEEF with sca_ack=0 -> dropped, overflow=1, sca_data=0xDEAD.
//     Scalar 0xCAFE with sca_ack=1 in the same cycle -> sca_data=0xCAFE, sca_valid=1.
//   - Wrap: 20 beats with random wb_ready (50%) -> scoreboard order/data exact,
//     no overflow.
//   - Assert rst with 5 entries queued -> next cycle count=0, wb_valid=0,
//     sca_valid=0, overflow=0.

Source files
------------

// File: rtl/valu_wb_queue.sv
// vALU writeback queue: buffers vector results for the VRF write port in a
// show-ahead FIFO and holds one scalar result until the scalar unit takes it.
// Results arrive with no backpressure. Overflow is sticky until reset.
module valu_wb_queue #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_vec,
    input  logic [ADDR_WIDTH-1:0]    in_addr,
    input  logic [BE_WIDTH-1:0]      in_be,
    input  logic                     in_w_reg,
    input  logic                     in_sca,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic [ADDR_WIDTH-1:0]    wb_addr,
    output logic [BE_WIDTH-1:0]      wb_be,
    output logic                     wb_w_reg,
    output logic                     sca_valid,
    output logic [DATA_WIDTH-1:0]    sca_data,
    input  logic                     sca_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Entry storage, one array per field
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [BE_WIDTH-1:0]   be_mem   [DEPTH];
    logic                  wreg_mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  sca_valid_q, sca_valid_d;
    logic [DATA_WIDTH-1:0] sca_data_q, sca_data_d;
    logic                  overflow_q, overflow_d;

    logic                  vec_push;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic                  sca_in;
    logic                  sca_load;
    logic                  sca_drop;
    logic [CNT_W-1:0]      free_cnt;

    // Next-state for FIFO pointers/occupancy, scalar holder and overflow flag
    always_comb begin
        vec_push = in_valid & ~in_sca;
        pop      = (count_q != '0) & wb_ready;
        full     = (count_q == DEPTH_CNT);
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok  = vec_push & (~full | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        sca_in      = in_valid & in_sca;
        sca_load    = sca_in & (~sca_valid_q | sca_ack);
        sca_drop    = sca_in & sca_valid_q & ~sca_ack;
        sca_valid_d = sca_valid_q;
        sca_data_d  = sca_data_q;
        if (sca_load) begin
            sca_valid_d = 1'b1;
            sca_data_d  = in_vec;
        end else if (sca_ack) begin
            sca_valid_d = 1'b0;
        end

        overflow_d = overflow_q | (vec_push & full & ~pop) | sca_drop;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sca_valid_q <= 1'b0;
            sca_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sca_valid_q <= sca_valid_d;
            sca_data_q  <= sca_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry write at the write pointer; storage itself needs no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_q] <= in_vec;
            addr_mem[wr_ptr_q] <= in_addr;
            be_mem[wr_ptr_q]   <= in_be;
            wreg_mem[wr_ptr_q] <= in_w_reg;
        end
    end

    assign free_cnt    = DEPTH_CNT - count_q;
    assign almost_full = (32'(free_cnt) <= AFULL_THRESH);

    assign wb_valid  = (count_q != '0);
    assign wb_data   = data_mem[rd_ptr_q];
    assign wb_addr   = addr_mem[rd_ptr_q];
    assign wb_be     = be_mem[rd_ptr_q];
    assign wb_w_reg  = wreg_mem[rd_ptr_q];
    assign sca_valid = sca_valid_q;
    assign sca_data  = sca_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_valu_wb_queue.sv
// Directed bench for valu_wb_queue with a scoreboard of expected FIFO entries
// and a small model of occupancy, scalar holder and overflow.
module tb_valu_wb_queue;

    localparam int DEPTH = 8;
    localparam int AFULL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_vec = '0;
    logic [31:0] in_addr = '0;
    logic [7:0]  in_be = '0;
    logic        in_w_reg = 1'b0;
    logic        in_sca = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [63:0] wb_data;
    logic [31:0] wb_addr;
    logic [7:0]  wb_be;
    logic        wb_w_reg;
    logic        sca_valid;
    logic [63:0] sca_data;
    logic        sca_ack = 1'b0;
    logic [3:0]  count;
    logic        almost_full;
    logic        overflow;

    typedef struct {
        logic [63:0] d;
        logic [31:0] a;
        logic [7:0]  be;
        logic        w;
    } ent_t;

    ent_t        sb[$];
    logic        m_ovf = 1'b0;
    logic        m_sv = 1'b0;
    logic [63:0] m_sd = '0;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;

    valu_wb_queue #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .BE_WIDTH(8),
        .DEPTH(DEPTH),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr), .in_be(in_be),
        .in_w_reg(in_w_reg), .in_sca(in_sca),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_be(wb_be), .wb_w_reg(wb_w_reg),
        .sca_valid(sca_valid), .sca_data(sca_data), .sca_ack(sca_ack),
        .count(count), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {32'hA5A5_0000 | a, ~a};
    endfunction

    // One clock: check at negedge, then advance the model on the posedge
    task automatic tick();
        bit   popm;
        bit   pushm;
        bit   was_full;
        bit   scm;
        ent_t e;
        ent_t h;
        @(negedge clk);
        chk("wb_valid", {63'd0, wb_valid}, {63'd0, sb.size() != 0});
        chk("count", {60'd0, count}, 64'(sb.size()));
        chk("almost_full", {63'd0, almost_full}, {63'd0, (DEPTH - sb.size()) <= AFULL});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("sca_valid", {63'd0, sca_valid}, {63'd0, m_sv});
        chk("sca_data", sca_data, m_sd);
        popm = !rst && wb_ready && sb.size() != 0;
        if (popm) begin
            h = sb[0];
            chk("wb_data", wb_data, h.d);
            chk("wb_addr", {32'd0, wb_addr}, {32'd0, h.a});
            chk("wb_be", {56'd0, wb_be}, {56'd0, h.be});
            chk("wb_w_reg", {63'd0, wb_w_reg}, {63'd0, h.w});
            delivered++;
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_ovf = 1'b0;
            m_sv = 1'b0;
            m_sd = '0;
        end else begin
            pushm = in_valid && !in_sca;
            scm = in_valid && in_sca;
            was_full = (sb.size() == DEPTH);
            if (popm) void'(sb.pop_front());
            if (pushm) begin
                if (!was_full || popm) begin
                    e.d = in_vec; e.a = in_addr; e.be = in_be; e.w = in_w_reg;
                    sb.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (scm && (!m_sv || sca_ack)) begin
                m_sv = 1'b1;
                m_sd = in_vec;
            end else if (scm) begin
                m_ovf = 1'b1;
            end else if (sca_ack) begin
                m_sv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic vpush(input logic [31:0] a, input logic [7:0] be);
        in_valid = 1'b1; in_sca = 1'b0;
        in_vec = pat(a); in_addr = a; in_be = be; in_w_reg = a[0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic spush(input logic [63:0] d, input logic ack);
        in_valid = 1'b1; in_sca = 1'b1; in_vec = d; sca_ack = ack;
        in_w_reg = 1'b1; in_addr = 32'h77; in_be = 8'hFF;
        tick();
        in_valid = 1'b0; in_sca = 1'b0; sca_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pushed;

        // Reset state
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_sca_valid", {63'd0, sca_valid}, 64'd0);
        chk("rst_sca_data", sca_data, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);

        // Three in-order beats with the VRF always ready; one has be==0
        wb_ready = 1'b1;
        delivered = 0;
        vpush(32'h10, 8'hFF);
        vpush(32'h11, 8'h00);
        vpush(32'h12, 8'h0F);
        idle(5);
        chk("basic_delivered", 64'(delivered), 64'd3);
        chk("basic_count0", {60'd0, count}, 64'd0);

        // Fill to DEPTH with no drain, 9th beat dropped, then drain exactly 8
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) vpush(32'h20 + 32'(i), 8'(i + 1));
        chk("fill_count", {60'd0, count}, 64'd8);
        chk("fill_afull", {63'd0, almost_full}, 64'd1);
        vpush(32'h2F, 8'hAA);
        chk("drop_overflow", {63'd0, overflow}, 64'd1);
        chk("drop_count", {60'd0, count}, 64'd8);
        wb_ready = 1'b1;
        delivered = 0;
        idle(12);
        chk("full_drain_n", 64'(delivered), 64'd8);

        // Full FIFO with simultaneous push and pop
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) vpush(32'h40 + 32'(i), 8'hC3);
        wb_ready = 1'b1;
        delivered = 0;
        vpush(32'h50, 8'h3C);
        chk("pushpop_count", {60'd0, count}, 64'd8);
        idle(12);
        chk("pushpop_drain_n", 64'(delivered), 64'd9);

        // Scalar holder
        do_reset();
        spush(64'hDEAD, 1'b0);
        chk("sca_first_valid", {63'd0, sca_valid}, 64'd1);
        chk("sca_first_count", {60'd0, count}, 64'd0);
        spush(64'hBEEF, 1'b0);
        chk("sca_drop_data", sca_data, 64'hDEAD);
        chk("sca_drop_ovf", {63'd0, overflow}, 64'd1);
        spush(64'hCAFE, 1'b1);
        chk("sca_replace_data", sca_data, 64'hCAFE);
        chk("sca_replace_valid", {63'd0, sca_valid}, 64'd1);
        sca_ack = 1'b1;
        tick();
        sca_ack = 1'b0;
        chk("sca_ack_clear", {63'd0, sca_valid}, 64'd0);
        idle(1);

        // Pointer wrap with random drain
        do_reset();
        delivered = 0;
        pushed = 0;
        for (int c = 0; c < 400 && (pushed < 20 || sb.size() != 0); c++) begin
            wb_ready = 1'($urandom_range(0, 1));
            if (pushed < 20 && sb.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
                vpush(32'h100 + 32'(pushed), 8'($urandom));
                pushed++;
            end else begin
                tick();
            end
        end
        chk("wrap_pushed", 64'(pushed), 64'd20);
        chk("wrap_delivered", 64'(delivered), 64'd20);
        chk("wrap_no_ovf", {63'd0, overflow}, 64'd0);

        // Reset while entries and a scalar are held
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) vpush(32'h200 + 32'(i), 8'h5A);
        spush(64'h1234, 1'b0);
        spush(64'h5678, 1'b0);
        chk("pre_rst_count", {60'd0, count}, 64'd5);
        wb_ready = 1'b1;
        do_reset();
        chk("mid_rst_count", {60'd0, count}, 64'd0);
        chk("mid_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("mid_rst_sca_valid", {63'd0, sca_valid}, 64'd0);
        chk("mid_rst_overflow", {63'd0, overflow}, 64'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
